// File: rtl/avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// avalon_bus_arbiter: two-master / one-slave Avalon-MM arbiter with an idle
// cycle between grants and saturating per-master completion counters.
// Revision: 1.0
// ============================================================================
module avalon_bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m0_address,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  input  logic [3:0]       m0_byteenable,
  output logic [31:0]      m0_readdata,
  output logic             m0_waitrequest,
  input  logic [31:0]      m1_address,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  input  logic [3:0]       m1_byteenable,
  output logic [31:0]      m1_readdata,
  output logic             m1_waitrequest,
  output logic [31:0]      s_address,
  output logic             s_read,
  output logic             s_write,
  output logic [31:0]      s_writedata,
  output logic [3:0]       s_byteenable,
  input  logic [31:0]      s_readdata,
  input  logic             s_waitrequest,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  // Encoding chosen so the state register is the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             prio_q,  prio_d;   // 1 = master 1 wins a tie
  logic [CNT_W-1:0] cnt0_q,  cnt0_d;
  logic [CNT_W-1:0] cnt1_q,  cnt1_d;

  logic req0, req1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    prio_d         = prio_q;
    cnt0_d         = cnt0_q;
    cnt1_d         = cnt1_q;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || !prio_q)) state_d = GNT0;
        else if (req1)                  state_d = GNT1;
      end
      GNT0: begin
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        if (!req0) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          prio_d  = ROUND_ROBIN;
          cnt0_d  = (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + CNT_W'(1);
        end
      end
      GNT1: begin
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        if (!req1) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          prio_d  = 1'b0;
          cnt1_d  = (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = state_q;
  assign grant_cnt0  = cnt0_q;
  assign grant_cnt1  = cnt1_q;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_avalon_bus_arbiter: round-robin and fixed-priority instances driven by
// shared directed + random stimulus, compared against a transaction model.
// Revision: 1.0
// ============================================================================
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] s_readdata = '0;
  logic        s_waitrequest = 1'b0;

  // round-robin instance (CNT_W 16)
  logic [31:0] rr_rd0, rr_rd1, rr_sa, rr_swd;
  logic        rr_w0, rr_w1, rr_sr, rr_sw;
  logic [3:0]  rr_sbe;
  logic [1:0]  rr_grant;
  logic [15:0] rr_c0, rr_c1;
  // fixed-priority instance (CNT_W 3 so saturation is reachable)
  logic [31:0] fp_rd0, fp_rd1, fp_sa, fp_swd;
  logic        fp_w0, fp_w1, fp_sr, fp_sw;
  logic [3:0]  fp_sbe;
  logic [1:0]  fp_grant;
  logic [2:0]  fp_c0, fp_c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.ROUND_ROBIN(1'b1), .CNT_W(16)) u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(rr_rd0), .m0_waitrequest(rr_w0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(rr_rd1), .m1_waitrequest(rr_w1),
    .s_address(rr_sa), .s_read(rr_sr), .s_write(rr_sw), .s_writedata(rr_swd),
    .s_byteenable(rr_sbe), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(rr_grant), .grant_cnt0(rr_c0), .grant_cnt1(rr_c1)
  );

  avalon_bus_arbiter #(.ROUND_ROBIN(1'b0), .CNT_W(3)) u_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(fp_rd0), .m0_waitrequest(fp_w0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(fp_rd1), .m1_waitrequest(fp_w1),
    .s_address(fp_sa), .s_read(fp_sr), .s_write(fp_sw), .s_writedata(fp_swd),
    .s_byteenable(fp_sbe), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(fp_grant), .grant_cnt0(fp_c0), .grant_cnt1(fp_c1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  int owner   [2] = '{-1, -1};   // master holding the bus, -1 when idle
  int favored [2] = '{0, 0};     // master that wins a tie
  int done    [2][2] = '{'{0, 0}, '{0, 0}};
  int cap     [2] = '{65535, 7};
  bit rr      [2] = '{1'b1, 1'b0};

  function automatic bit wants(int m);
    return (m == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; favored[k] = 0; done[k][0] = 0; done[k][1] = 0;
    end
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (!reset) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (owner[k] < 0) begin
          if (wants(0) && wants(1)) owner[k] = favored[k];
          else if (wants(0))        owner[k] = 0;
          else if (wants(1))        owner[k] = 1;
        end else if (!wants(owner[k])) begin
          owner[k] = -1;
        end else if (!s_waitrequest) begin
          if (done[k][owner[k]] < cap[k]) done[k][owner[k]]++;
          if (rr[k]) favored[k] = 1 - owner[k];
          owner[k] = -1;
        end
      end
    end
  end

  task automatic check_inst(input int k, input string tag,
                            input logic [31:0] sa, input logic sr, input logic sw,
                            input logic [31:0] swd, input logic [3:0] sbe,
                            input logic w0, input logic w1,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [1:0] g, input logic [31:0] c0, input logic [31:0] c1);
    logic [31:0] e_sa, e_swd;
    logic [3:0]  e_sbe;
    logic        e_sr, e_sw, e_w0, e_w1;
    logic [1:0]  e_g;
    e_sa = '0; e_swd = '0; e_sbe = '0; e_sr = 1'b0; e_sw = 1'b0; e_w0 = 1'b1; e_w1 = 1'b1; e_g = 2'b00;
    if (owner[k] == 0) begin
      e_g = 2'b01; e_sa = m0_address; e_swd = m0_writedata; e_sbe = m0_byteenable;
      e_sw = m0_write; e_sr = m0_read & ~m0_write; e_w0 = s_waitrequest;
    end else if (owner[k] == 1) begin
      e_g = 2'b10; e_sa = m1_address; e_swd = m1_writedata; e_sbe = m1_byteenable;
      e_sw = m1_write; e_sr = m1_read & ~m1_write; e_w1 = s_waitrequest;
    end
    chk({tag, " grant"},          {30'd0, g},  {30'd0, e_g});
    chk({tag, " s_address"},      sa,          e_sa);
    chk({tag, " s_read"},         {31'd0, sr}, {31'd0, e_sr});
    chk({tag, " s_write"},        {31'd0, sw}, {31'd0, e_sw});
    chk({tag, " s_writedata"},    swd,         e_swd);
    chk({tag, " s_byteenable"},   {28'd0, sbe}, {28'd0, e_sbe});
    chk({tag, " m0_waitrequest"}, {31'd0, w0}, {31'd0, e_w0});
    chk({tag, " m1_waitrequest"}, {31'd0, w1}, {31'd0, e_w1});
    chk({tag, " m0_readdata"},    rd0,         s_readdata);
    chk({tag, " m1_readdata"},    rd1,         s_readdata);
    chk({tag, " grant_cnt0"},     c0,          32'(done[k][0]));
    chk({tag, " grant_cnt1"},     c1,          32'(done[k][1]));
  endtask

  always @(negedge clk) begin
    check_inst(0, "rr", rr_sa, rr_sr, rr_sw, rr_swd, rr_sbe, rr_w0, rr_w1,
               rr_rd0, rr_rd1, rr_grant, 32'(rr_c0), 32'(rr_c1));
    check_inst(1, "fp", fp_sa, fp_sr, fp_sw, fp_swd, fp_sbe, fp_w0, fp_w1,
               fp_rd0, fp_rd1, fp_grant, 32'(fp_c0), 32'(fp_c1));
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  logic [1:0] rr_seq [8];

  initial begin
    rr_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    repeat (3) step();
    chk("reset grant", {30'd0, rr_grant}, 32'd0);
    chk("reset waitreq", {30'd0, rr_w0, rr_w1}, 32'd3);
    chk("reset s_read", {31'd0, rr_sr}, 32'd0);
    chk("reset cnt", 32'(rr_c0) + 32'(fp_c1), 32'd0);
    reset = 1'b1;
    step();

    // single CPU read, zero-wait slave
    m0_read = 1'b1; m0_address = 32'h04;
    step();
    s_readdata = 32'h2402_0010; s_waitrequest = 1'b0;
    #1;
    chk("t1 grant", {30'd0, rr_grant}, 32'd1);
    chk("t1 m0_waitrequest", {31'd0, rr_w0}, 32'd0);
    chk("t1 m0_readdata", rr_rd0, 32'h2402_0010);
    chk("t1 s_address", rr_sa, 32'h04);
    step();
    idle_masters();
    chk("t1 back to idle", {30'd0, rr_grant}, 32'd0);
    chk("t1 rr cnt0", 32'(rr_c0), 32'd1);
    chk("t1 fp cnt0", 32'(fp_c0), 32'd1);

    // continuous contention
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2 rr grant seq", {30'd0, rr_grant}, {30'd0, rr_seq[i]});
      chk("t2 fp grant seq", {30'd0, fp_grant}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2 fp m1_waitrequest", {31'd0, fp_w1}, 32'd1);
    end
    idle_masters();
    chk("t2 rr cnt0", 32'(rr_c0), 32'd3);
    chk("t2 rr cnt1", 32'(rr_c1), 32'd2);
    chk("t2 fp cnt0", 32'(fp_c0), 32'd5);
    chk("t2 fp cnt1", 32'(fp_c1), 32'd0);

    // wait-stated write from m1
    m1_write = 1'b1; m1_address = 32'h1C; m1_writedata = 32'h8; m1_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) s_waitrequest = 1'b0;
      #1;
      chk("t3 s_write", {31'd0, rr_sw}, 32'd1);
      chk("t3 s_writedata", rr_swd, 32'h8);
      chk("t3 s_address", rr_sa, 32'h1C);
      chk("t3 m0_waitrequest", {31'd0, rr_w0}, 32'd1);
      chk("t3 m1_waitrequest", {31'd0, rr_w1}, (i == 3) ? 32'd0 : 32'd1);
    end
    step();
    idle_masters();
    chk("t3 rr cnt1", 32'(rr_c1), 32'd3);
    chk("t3 fp cnt1", 32'(fp_c1), 32'd1);

    // saturation of the 3-bit counter: four more m0 transfers
    m0_read = 1'b1;
    repeat (8) step();
    idle_masters();
    chk("t4 fp cnt0 saturated", 32'(fp_c0), 32'd7);
    chk("t4 rr cnt0", 32'(rr_c0), 32'd7);

    // asynchronous reset in the middle of a stalled m0 read
    m0_read = 1'b1; s_waitrequest = 1'b1;
    step();
    step();
    chk("t5 stalled grant", {30'd0, rr_grant}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5 async s_read", {31'd0, rr_sr}, 32'd0);
    chk("t5 async grant", {30'd0, rr_grant}, 32'd0);
    chk("t5 async cnt", 32'(rr_c0) + 32'(rr_c1) + 32'(fp_c0), 32'd0);
    chk("t5 async waitreq", {30'd0, rr_w0, fp_w0}, 32'd3);
    step();
    reset = 1'b1; s_waitrequest = 1'b0;
    step();
    chk("t5 retry grant", {30'd0, rr_grant}, 32'd1);
    step();
    idle_masters();
    chk("t5 retry cnt0", 32'(rr_c0), 32'd1);

    // abandon during a stall, then read+write together
    m0_read = 1'b1; s_waitrequest = 1'b1;
    step();
    step();
    idle_masters();
    step();
    chk("t6 abandon grant", {30'd0, rr_grant}, 32'd0);
    chk("t6 abandon cnt0", 32'(rr_c0), 32'd1);
    m0_read = 1'b1; m0_write = 1'b1;
    step();
    #1;
    chk("t6 rw s_write", {31'd0, rr_sw}, 32'd1);
    chk("t6 rw s_read", {31'd0, rr_sr}, 32'd0);
    s_waitrequest = 1'b0;
    step();
    idle_masters();
    chk("t6 rw cnt0", 32'(rr_c0), 32'd2);

    // random traffic, requests tend to persist across cycles
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(3) == 0) begin
        m0_read = 1'($urandom); m0_write = ($urandom_range(3) == 0);
        m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        m1_read = 1'($urandom); m1_write = ($urandom_range(3) == 0);
        m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
      end
      s_waitrequest = 1'($urandom);
      s_readdata = $urandom;
    end
    idle_masters();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
